// File: rtl/enemy_pkg.sv
// ---------------------------------------------------------------------------
// enemy_pkg : shared types and constants for the enemy lane controller
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package enemy_pkg;

  localparam int POS_W = 5;
  localparam int NUM_SLOTS = 2;
  localparam logic [POS_W-1:0] POS_INACTIVE = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK   = 2'd1,
    ST_ARRIVE = 2'd2,
    ST_HIT    = 2'd3
  } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/enemy_slot.sv
// ---------------------------------------------------------------------------
// enemy_slot : one enemy slot FSM with its per-state tick counter
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module enemy_slot
  import enemy_pkg::*;
#(
  parameter int START_POS    = 20,
  parameter int PLAYER_POS   = 10,
  parameter int HIT_TICKS    = 4,
  parameter int ARRIVE_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic             hit_cmd,
  input  logic             kill,
  output logic [POS_W-1:0] pos,
  output logic             hit,
  output logic             arrived_timeout,
  output slot_state_t      state
);

  localparam logic [POS_W-1:0] C_START       = POS_W'(START_POS);
  localparam logic [POS_W-1:0] C_PLAYER      = POS_W'(PLAYER_POS);
  localparam logic [POS_W-1:0] C_HIT_LAST    = POS_W'(HIT_TICKS - 1);
  localparam logic [POS_W-1:0] C_ARRIVE_LAST = POS_W'(ARRIVE_TICKS - 1);

  logic [POS_W-1:0] cnt;

  // A hit landing on the final arrive tick cancels the life charge.
  assign arrived_timeout = tick && (state == ST_ARRIVE) && (cnt == C_ARRIVE_LAST) && !hit_cmd;

  always_ff @(posedge clk) begin
    if (!rst || kill) begin
      state <= ST_IDLE;
      pos   <= POS_INACTIVE;
      hit   <= 1'b0;
      cnt   <= '0;
    end else if (hit_cmd) begin
      state <= ST_HIT;
      hit   <= 1'b1;
      cnt   <= '0;
    end else if (load) begin
      state <= ST_WALK;
      pos   <= C_START;
      hit   <= 1'b0;
      cnt   <= '0;
    end else if (tick) begin
      case (state)
        ST_WALK: begin
          pos <= pos - 1'b1;
          if (pos == C_PLAYER + 1'b1) begin
            state <= ST_ARRIVE;
            cnt   <= '0;
          end
        end
        ST_ARRIVE: begin
          if (cnt == C_ARRIVE_LAST) begin
            state <= ST_IDLE;
            pos   <= POS_INACTIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HIT: begin
          if (cnt == C_HIT_LAST) begin
            state <= ST_IDLE;
            pos   <= POS_INACTIVE;
            hit   <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/enemy_lane_ctrl.sv
// ---------------------------------------------------------------------------
// enemy_lane_ctrl : tick sync, spawn/attack arbitration, score and lives
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module enemy_lane_ctrl
  import enemy_pkg::*;
#(
  parameter int START_POS    = 20,
  parameter int PLAYER_POS   = 10,
  parameter int RANGE        = 3,
  parameter int HIT_TICKS    = 4,
  parameter int ARRIVE_TICKS = 2,
  parameter int LIVES_INIT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_22,
  input  logic             spawn,
  input  logic             attack,
  output logic [POS_W-1:0] pos_0,
  output logic [POS_W-1:0] pos_1,
  output logic             hit_0,
  output logic             hit_1,
  output logic [7:0]       score,
  output logic [1:0]       lives,
  output logic             game_over
);

  if (START_POS > 31 || PLAYER_POS == 0 || START_POS <= PLAYER_POS) begin : g_param_check
    $error("enemy_lane_ctrl: START_POS must be <= 31 and > PLAYER_POS, PLAYER_POS must be > 0");
  end

  localparam logic [POS_W-1:0] C_PLAYER = POS_W'(PLAYER_POS);
  localparam logic [POS_W-1:0] C_REACH  = POS_W'(PLAYER_POS + RANGE);

  logic sync_1, sync_2, sync_3;
  logic tick;

  slot_state_t      state_s   [NUM_SLOTS];
  logic [POS_W-1:0] pos_s     [NUM_SLOTS];
  logic             hit_s     [NUM_SLOTS];
  logic             timeout_s [NUM_SLOTS];
  logic             load_s    [NUM_SLOTS];
  logic             hit_cmd_s [NUM_SLOTS];
  logic             elig      [NUM_SLOTS];

  logic       target_1;
  logic [1:0] dec;
  logic       lose_all;
  logic       kill;
  logic       score_inc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      sync_1 <= clk_22;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  assign tick = sync_2 && !sync_3;

  // Attack targets the eligible slot closest to the player; slot 0 wins ties.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      elig[i] = ((state_s[i] == ST_WALK) || (state_s[i] == ST_ARRIVE)) &&
                (pos_s[i] >= C_PLAYER) && (pos_s[i] <= C_REACH);
    end
    target_1     = elig[1] && (!elig[0] || (pos_s[1] < pos_s[0]));
    hit_cmd_s[0] = attack && !game_over && elig[0] && !target_1;
    hit_cmd_s[1] = attack && !game_over && target_1;
    load_s[0]    = spawn && !game_over && (state_s[0] == ST_IDLE);
    load_s[1]    = spawn && !game_over && (state_s[0] != ST_IDLE) && (state_s[1] == ST_IDLE);
  end

  assign dec       = {1'b0, timeout_s[0]} + {1'b0, timeout_s[1]};
  assign lose_all  = (dec != 2'd0) && (lives <= dec);
  assign kill      = game_over || lose_all;
  assign score_inc = (hit_cmd_s[0] || hit_cmd_s[1]) && !kill;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    enemy_slot #(
      .START_POS   (START_POS),
      .PLAYER_POS  (PLAYER_POS),
      .HIT_TICKS   (HIT_TICKS),
      .ARRIVE_TICKS(ARRIVE_TICKS)
    ) u_slot (
      .clk            (clk),
      .rst            (rst),
      .tick           (tick),
      .load           (load_s[g]),
      .hit_cmd        (hit_cmd_s[g]),
      .kill           (kill),
      .pos            (pos_s[g]),
      .hit            (hit_s[g]),
      .arrived_timeout(timeout_s[g]),
      .state          (state_s[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      score     <= 8'd0;
      lives     <= 2'(LIVES_INIT);
      game_over <= 1'b0;
    end else if (!game_over) begin
      if (dec != 2'd0) begin
        lives <= lose_all ? 2'd0 : lives - dec;
      end
      if (lose_all) begin
        game_over <= 1'b1;
      end
      if (score_inc && score != 8'hFF) begin
        score <= score + 8'd1;
      end
    end
  end

  assign pos_0 = pos_s[0];
  assign pos_1 = pos_s[1];
  assign hit_0 = hit_s[0];
  assign hit_1 = hit_s[1];

endmodule

`default_nettype wire

// File: tb/tb_enemy_lane_ctrl.sv
// ---------------------------------------------------------------------------
// tb_enemy_lane_ctrl : directed scenarios with a queued-expectation scoreboard
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_enemy_lane_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_22 = 1'b0;
  logic       spawn = 1'b0;
  logic       attack = 1'b0;
  logic [4:0] pos_0, pos_1;
  logic       hit_0, hit_1;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [4:0] p0;
    logic [4:0] p1;
    logic       h0;
    logic       h1;
    logic [7:0] sc;
    logic [1:0] lv;
    logic       go;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  enemy_lane_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .clk_22   (clk_22),
    .spawn    (spawn),
    .attack   (attack),
    .pos_0    (pos_0),
    .pos_1    (pos_1),
    .hit_0    (hit_0),
    .hit_1    (hit_1),
    .score    (score),
    .lives    (lives),
    .game_over(game_over)
  );

  // Outputs are registered, so a snapshot taken mid-cycle is stable.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (pos_0 !== e.p0 || pos_1 !== e.p1 || hit_0 !== e.h0 || hit_1 !== e.h1 ||
            score !== e.sc || lives !== e.lv || game_over !== e.go) begin
          errors++;
          $display("FAIL %s: got p0=%0d p1=%0d h0=%0b h1=%0b score=%0d lives=%0d go=%0b, want p0=%0d p1=%0d h0=%0b h1=%0b score=%0d lives=%0d go=%0b",
                   e.name, pos_0, pos_1, hit_0, hit_1, score, lives, game_over,
                   e.p0, e.p1, e.h0, e.h1, e.sc, e.lv, e.go);
        end
      end
    end
  end

  task automatic expect_state(input string name, input int p0, input int p1, input bit h0,
                              input bit h1, input int sc, input int lv, input bit go);
    exp_t e;
    e.name = name;
    e.p0 = 5'(p0);
    e.p1 = 5'(p1);
    e.h0 = h0;
    e.h1 = h1;
    e.sc = 8'(sc);
    e.lv = 2'(lv);
    e.go = go;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic pulse_spawn();
    spawn = 1'b1;
    step();
    spawn = 1'b0;
  endtask

  task automatic pulse_attack();
    attack = 1'b1;
    step();
    attack = 1'b0;
  endtask

  // One slow-clock period; optional spawn/attack land on the tick cycle itself.
  task automatic tick_with(input bit a, input bit s);
    clk_22 = 1'b1;
    step(2);
    attack = a;
    spawn  = s;
    step();
    attack = 1'b0;
    spawn  = 1'b0;
    step();
    clk_22 = 1'b0;
    step(3);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick_with(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    expect_state("reset", 0, 0, 0, 0, 0, 3, 0);
    step();

    // March to the player and charge a life
    tick_with(1'b0, 1'b1);
    expect_state("spawn_on_tick", 20, 0, 0, 0, 0, 3, 0);
    ticks(1);
    expect_state("first_tick", 19, 0, 0, 0, 0, 3, 0);
    ticks(9);
    expect_state("arrive", 10, 0, 0, 0, 0, 3, 0);
    ticks(1);
    expect_state("arrive_wait", 10, 0, 0, 0, 0, 3, 0);
    ticks(1);
    expect_state("arrive_timeout", 0, 0, 0, 0, 0, 2, 0);

    // Single hit holds position for HIT_TICKS
    do_reset();
    expect_state("reset_b", 0, 0, 0, 0, 0, 3, 0);
    pulse_spawn();
    ticks(7);
    expect_state("walk_13", 13, 0, 0, 0, 0, 3, 0);
    pulse_attack();
    expect_state("hit_13", 13, 0, 1, 0, 1, 3, 0);
    ticks(3);
    expect_state("hit_hold", 13, 0, 1, 0, 1, 3, 0);
    ticks(1);
    expect_state("hit_done", 0, 0, 0, 0, 1, 3, 0);

    // Two slots, dropped spawn, lowest-pos target, slot reuse
    do_reset();
    pulse_spawn();
    ticks(2);
    pulse_spawn();
    expect_state("second_spawn", 18, 20, 0, 0, 0, 3, 0);
    pulse_spawn();
    expect_state("spawn_dropped", 18, 20, 0, 0, 0, 3, 0);
    ticks(6);
    expect_state("two_walk", 12, 14, 0, 0, 0, 3, 0);
    pulse_attack();
    expect_state("hit_lower", 12, 14, 1, 0, 1, 3, 0);
    ticks(1);
    expect_state("hit_frozen_other_moves", 12, 13, 1, 0, 1, 3, 0);
    ticks(3);
    expect_state("slot0_free_slot1_arrive", 0, 10, 0, 0, 1, 3, 0);
    pulse_spawn();
    expect_state("reuse_slot0", 20, 10, 0, 0, 1, 3, 0);
    pulse_attack();
    expect_state("hit_slot1", 20, 10, 0, 1, 2, 3, 0);

    // Out-of-range attack, then tie goes to slot 0, then slot 1
    do_reset();
    pulse_spawn();
    pulse_spawn();
    ticks(4);
    pulse_attack();
    expect_state("attack_out_of_range", 16, 16, 0, 0, 0, 3, 0);
    ticks(3);
    pulse_attack();
    expect_state("tie_slot0", 13, 13, 1, 0, 1, 3, 0);
    pulse_attack();
    expect_state("tie_then_slot1", 13, 13, 1, 1, 2, 3, 0);

    // Attack on the final arrive tick beats the life charge
    do_reset();
    pulse_spawn();
    ticks(11);
    tick_with(1'b1, 1'b0);
    expect_state("hit_beats_timeout", 10, 0, 1, 0, 1, 3, 0);

    // Lives run out: double charge, then game over with a slot force-cleared
    do_reset();
    pulse_spawn();
    pulse_spawn();
    ticks(12);
    expect_state("double_charge", 0, 0, 0, 0, 0, 1, 0);
    pulse_spawn();
    ticks(2);
    pulse_spawn();
    ticks(10);
    expect_state("game_over", 0, 0, 0, 0, 0, 0, 1);
    pulse_spawn();
    pulse_attack();
    ticks(1);
    expect_state("game_over_frozen", 0, 0, 0, 0, 0, 0, 1);
    do_reset();
    expect_state("reset_after_over", 0, 0, 0, 0, 0, 3, 0);

    step(3);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
